// File: rtl/uart_receiver_two_bytes.sv
// 8N1 UART receiver: oversampled bit recovery, pairing of good bytes into 16-bit words,
// valid/ready output slot and sticky framing/overrun flags.
module uart_receiver_two_bytes #(
  parameter int ClocksPerBaud = 1250,
  parameter bit FirstByteHigh = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_in,
  output logic [15:0] word_out,
  output logic        word_valid_out,
  input  logic        word_ready_in,
  output logic        framing_error_out,
  output logic        overrun_error_out,
  input  logic        clear_errors_in,
  output logic        busy_out
);

  localparam int CntW = $clog2(ClocksPerBaud);
  localparam logic [CntW-1:0] CntHalf = CntW'(ClocksPerBaud / 2 - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(ClocksPerBaud - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic            rx_meta, rx_s;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q, held_q;
  logic            phase_q;
  logic            cnt_zero;
  logic            load_half, load_full, sample_bit, byte_good, byte_bad;
  logic [15:0]     pair_word;
  logic            accept, word_done, word_load, overrun_evt;

  assign cnt_zero = (cnt_q == '0);

  // Line idles high, so the synchronizer resets to 1 to avoid a fake start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!rx_s) state_d = START;
      START: if (cnt_zero) state_d = rx_s ? IDLE : DATA;
      DATA:  if (cnt_zero && bit_idx_q == 3'd7) state_d = STOP;
      STOP:  if (cnt_zero) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_half  = 1'b0;
    load_full  = 1'b0;
    sample_bit = 1'b0;
    byte_good  = 1'b0;
    byte_bad   = 1'b0;
    busy_out   = (state_q != IDLE);
    case (state_q)
      IDLE:  load_half = !rx_s;
      START: load_full = cnt_zero && !rx_s;
      DATA: begin
        sample_bit = cnt_zero;
        load_full  = cnt_zero;
      end
      STOP: begin
        byte_good = cnt_zero && rx_s;
        byte_bad  = cnt_zero && !rx_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      if (load_half)      cnt_q <= CntHalf;
      else if (load_full) cnt_q <= CntFull;
      else if (!cnt_zero) cnt_q <= cnt_q - CntW'(1);
      if (state_q == START) bit_idx_q <= 3'd0;
      if (sample_bit) begin
        shift_q[bit_idx_q] <= rx_s;
        bit_idx_q          <= bit_idx_q + 3'd1;
      end
    end
  end

  assign pair_word   = FirstByteHigh ? {held_q, shift_q} : {shift_q, held_q};
  assign accept      = word_valid_out && word_ready_in;
  assign word_done   = byte_good && phase_q;
  assign word_load   = word_done && (!word_valid_out || word_ready_in);
  assign overrun_evt = word_done && word_valid_out && !word_ready_in;

  // A bad stop bit resynchronizes pairing so the next good byte starts a new word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q           <= 1'b0;
      held_q            <= '0;
      word_out          <= '0;
      word_valid_out    <= 1'b0;
      framing_error_out <= 1'b0;
      overrun_error_out <= 1'b0;
    end else begin
      if (byte_bad) begin
        phase_q <= 1'b0;
      end else if (byte_good) begin
        if (!phase_q) held_q <= shift_q;
        phase_q <= !phase_q;
      end

      if (word_load) begin
        word_out       <= pair_word;
        word_valid_out <= 1'b1;
      end else if (accept) begin
        word_valid_out <= 1'b0;
      end

      if (byte_bad)             framing_error_out <= 1'b1;
      else if (clear_errors_in) framing_error_out <= 1'b0;

      if (overrun_evt)          overrun_error_out <= 1'b1;
      else if (clear_errors_in) overrun_error_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_receiver_two_bytes.sv
// Bench for uart_receiver_two_bytes: byte-level reference model feeds an expected-word
// queue, a negedge monitor pops and compares every accepted word.
module tb_uart_receiver_two_bytes;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_in;
  logic [15:0] word_out;
  logic        word_valid_out;
  logic        word_ready_in;
  logic        framing_error_out;
  logic        overrun_error_out;
  logic        clear_errors_in;
  logic        busy_out;

  uart_receiver_two_bytes #(.ClocksPerBaud(4), .FirstByteHigh(1'b1)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rx_in            (rx_in),
    .word_out         (word_out),
    .word_valid_out   (word_valid_out),
    .word_ready_in    (word_ready_in),
    .framing_error_out(framing_error_out),
    .overrun_error_out(overrun_error_out),
    .clear_errors_in  (clear_errors_in),
    .busy_out         (busy_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int accepted = 0;

  logic [15:0] exp_q[$];
  logic        m_phase = 1'b0;
  logic [7:0]  m_held = 8'h00;
  logic        exp_fe = 1'b0;
  logic        exp_oe = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: a word exists only for two consecutive good bytes; it is lost if an
  // earlier expected word is still waiting to be consumed.
  task automatic model_byte(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok) begin
      exp_fe  = 1'b1;
      m_phase = 1'b0;
    end else if (!m_phase) begin
      m_held  = b;
      m_phase = 1'b1;
    end else begin
      m_phase = 1'b0;
      if (exp_q.size() != 0) exp_oe = 1'b1;
      else                   exp_q.push_back({m_held, b});
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    model_byte(b, stop_ok);
    rx_in = 1'b0;
    tick(4);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      tick(4);
    end
    rx_in = stop_ok;
    tick(4);
    rx_in = 1'b1;
    if (!stop_ok) tick(4);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic pulse_clear();
    clear_errors_in = 1'b1;
    tick(1);
    clear_errors_in = 1'b0;
    exp_fe = 1'b0;
    exp_oe = 1'b0;
    tick(2);
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_fe"}, framing_error_out, exp_fe);
    chk({tag, "_oe"}, overrun_error_out, exp_oe);
  endtask

  logic [15:0] prev_word;
  logic        prev_hold = 1'b0;
  logic [15:0] exp_w;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("valid_held", word_valid_out, 1);
        chk("word_stable", word_out, prev_word);
      end
      if (word_valid_out && word_ready_in) begin
        accepted++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word got=%h required=none at %0t", word_out, $time);
        end else begin
          exp_w = exp_q.pop_front();
          chk("word", word_out, exp_w);
        end
      end
      prev_hold = word_valid_out && !word_ready_in;
      prev_word = word_out;
    end
  end

  initial begin
    int acc0;
    logic seen_busy;
    logic [7:0] rb;
    logic rok;

    rst_n = 1'b0;
    rx_in = 1'b1;
    word_ready_in = 1'b1;
    clear_errors_in = 1'b0;
    tick(5);
    rst_n = 1'b1;
    tick(100);
    chk("reset_valid", word_valid_out, 0);
    chk("reset_busy", busy_out, 0);
    chk("reset_word", word_out, 0);
    check_flags("reset");

    // Back-to-back pair
    acc0 = accepted;
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    tick(10);
    wait_drain("drain_a53c");
    chk("one_pulse", accepted - acc0, 1);
    chk("word_a53c", word_out, 16'hA53C);
    check_flags("a53c");

    // Overrun with consumer stalled
    word_ready_in = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    tick(10);
    chk("ovr_word", word_out, 16'h1122);
    chk("ovr_valid", word_valid_out, 1);
    check_flags("ovr");
    word_ready_in = 1'b1;
    @(negedge clk);
    chk("ovr_valid_at_accept", word_valid_out, 1);
    @(negedge clk);
    chk("ovr_valid_dropped", word_valid_out, 0);
    tick(1);
    wait_drain("drain_ovr");
    pulse_clear();
    check_flags("clr1");

    // Framing error breaks pairing
    send_frame(8'h55, 1'b0);
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    tick(10);
    wait_drain("drain_fe");
    chk("fe_word", word_out, 16'h0102);
    check_flags("fe");

    // One-clock glitch is a false start
    acc0 = accepted;
    rx_in = 1'b0;
    tick(1);
    rx_in = 1'b1;
    seen_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy_out) seen_busy = 1'b1;
    end
    tick(4);
    chk("glitch_seen_busy", seen_busy, 1);
    chk("glitch_busy_idle", busy_out, 0);
    chk("glitch_no_word", accepted - acc0, 0);
    check_flags("glitch");
    pulse_clear();

    // Randomized byte stream with occasional bad stop bits
    for (int k = 0; k < 30; k++) begin
      rb  = 8'($urandom);
      rok = ($urandom_range(0, 7) != 0);
      send_frame(rb, rok);
      tick($urandom_range(1, 5));
    end
    tick(10);
    wait_drain("drain_rand");
    check_flags("rand");
    pulse_clear();
    check_flags("rand_clr");

    // Reset mid-frame with a held byte pending
    send_frame(8'h77, 1'b1);
    rx_in = 1'b0;
    tick(4);
    for (int i = 0; i < 4; i++) begin
      rx_in = i[0];
      tick(4);
    end
    rx_in = 1'b1;
    tick(2);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    m_phase = 1'b0;
    exp_fe  = 1'b0;
    exp_oe  = 1'b0;
    tick(10);
    chk("midrst_busy", busy_out, 0);
    chk("midrst_valid", word_valid_out, 0);
    send_frame(8'hDE, 1'b1);
    send_frame(8'hAD, 1'b1);
    tick(10);
    wait_drain("drain_dead");
    chk("dead_word", word_out, 16'hDEAD);
    pulse_clear();
    check_flags("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
